// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and constants for the push-button conditioner
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  localparam int BTN_UP        = 0;
  localparam int BTN_DOWN      = 1;
  localparam int BTN_SET_CLOCK = 2;
  localparam int BTN_SET_ALARM = 3;

  localparam logic [3:0] DEFAULT_REPEAT_MASK = 4'b0011;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for a terminal count of n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: 2-FF synchroniser, debounce counter and press/repeat FSM
// Auto-repeat (HELD -> REPEAT) exists only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  input  logic repeat_en,
  output logic level,
  output logic pulse
);

  localparam int            DW     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] dcnt;
  logic          toggle;
  btn_state_e    state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ~raw_n;
      sync2 <= sync1;
    end
  end

  assign toggle = (sync2 != level) && (dcnt == D_LAST);

  // Any cycle that agrees with the accepted level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt  <= '0;
      level <= 1'b0;
    end else if (sync2 == level || toggle) begin
      dcnt  <= '0;
      level <= level ^ toggle;
    end else begin
      dcnt  <= dcnt + 1'b1;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int            RW          = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;

  // An accepted release takes priority over a repeat due in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rcnt  <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (toggle && level) begin
        state <= IDLE;
        rcnt  <= '0;
      end else begin
        case (state)
          IDLE: if (toggle) begin
            state <= HELD;
            rcnt  <= '0;
            pulse <= 1'b1;
          end
          HELD: if (repeat_en) begin
            if (rcnt == DELAY_LAST) begin
              state <= REPEAT;
              rcnt  <= '0;
              pulse <= 1'b1;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          REPEAT: if (rcnt == PERIOD_LAST) begin
            rcnt  <= '0;
            pulse <= 1'b1;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
  logic unused_repeat_en;
  assign unused_repeat_en = repeat_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (toggle && level) begin
        state <= IDLE;
      end else if (state == IDLE && toggle) begin
        state <= HELD;
        pulse <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - debounced levels and press/repeat events for the alarm-clock buttons
// Auto-repeat on REPEAT_MASK channels is built only when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int               N_BTN           = 4,
  parameter int               DEBOUNCE_CYCLES = 1_000_000,
  parameter int               REPEAT_DELAY    = 25_000_000,
  parameter int               REPEAT_PERIOD   = 10_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(DEFAULT_REPEAT_MASK)
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [N_BTN-1:0] btn_raw_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_event
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk_clk),
      .rst_n    (reset_reset_n),
      .raw_n    (btn_raw_n[i]),
      .repeat_en(REPEAT_MASK[i]),
      .level    (btn_level[i]),
      .pulse    (btn_event[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed self-checking bench for btn_conditioner
// Expectations follow BTN_AUTOREPEAT_EN when it is defined.
module tb_btn_conditioner;
  import btn_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw_n;
  logic [3:0] level;
  logic [3:0] ev;

  int n_chk = 0;
  int n_err = 0;
  int ev_cnt[4]   = '{default: 0};
  int rise_cnt[4] = '{default: 0};
  logic [3:0] level_q = 4'h0;
  int b_ev;
  int b_rise;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .btn_raw_n    (raw_n),
    .btn_level    (level),
    .btn_event    (ev)
  );

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ev[i] === 1'b1) ev_cnt[i]++;
      if (level[i] === 1'b1 && level_q[i] !== 1'b1) rise_cnt[i]++;
    end
    level_q = level;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // k = edges since acceptance, rel_k = edge at which the release is accepted.
  function automatic logic exp_ev(input int k, input int rel_k);
`ifdef BTN_AUTOREPEAT_EN
    return (k == 0) || (k >= 10 && k < rel_k && ((k - 10) % 3) == 0);
`else
    return (k == 0);
`endif
  endfunction

  initial begin
    rst_n = 1'b1;
    raw_n = 4'h0;
    #1 rst_n = 1'b0;

    // reset with every button pressed
    repeat (3) tick();
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_event", 32'(ev), 32'h0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_level_e5", 32'(level), 32'h0);
    tick();
    chk("post_rst_level_e6", 32'(level), 32'hF);
    chk("post_rst_event_e6", 32'(ev), 32'hF);
    raw_n = 4'hF;
    tick();
    chk("post_rst_event_e7", 32'(ev), 32'h0);
    repeat (12) tick();
    chk("post_rst_released", 32'(level), 32'h0);
    chk("post_rst_ev_total", 32'(ev_cnt[0] + ev_cnt[1] + ev_cnt[2] + ev_cnt[3]), 32'd4);

    // clean press/release on set_clock
    b_ev = ev_cnt[BTN_SET_CLOCK];
    raw_n[BTN_SET_CLOCK] = 1'b0;
    repeat (5) tick();
    chk("ch2_level_e5", 32'(level[2]), 32'h0);
    tick();
    chk("ch2_level_e6", 32'(level[2]), 32'h1);
    chk("ch2_event_e6", 32'(ev[2]), 32'h1);
    tick();
    chk("ch2_event_e7", 32'(ev[2]), 32'h0);
    repeat (13) tick();
    raw_n[BTN_SET_CLOCK] = 1'b1;
    repeat (5) tick();
    chk("ch2_level_e25", 32'(level[2]), 32'h1);
    tick();
    chk("ch2_level_e26", 32'(level[2]), 32'h0);
    chk("ch2_event_e26", 32'(ev[2]), 32'h0);
    repeat (4) tick();
    chk("ch2_ev_count", 32'(ev_cnt[2] - b_ev), 32'd1);

    // bouncing press on up
    b_ev   = ev_cnt[BTN_UP];
    b_rise = rise_cnt[BTN_UP];
    raw_n[BTN_UP] = 1'b0;
    repeat (2) tick();
    raw_n[BTN_UP] = 1'b1;
    repeat (2) tick();
    raw_n[BTN_UP] = 1'b0;
    repeat (5) tick();
    chk("ch0_bounce_level_e9", 32'(level[0]), 32'h0);
    tick();
    chk("ch0_bounce_level_e10", 32'(level[0]), 32'h1);
    chk("ch0_bounce_event_e10", 32'(ev[0]), 32'h1);
    raw_n[BTN_UP] = 1'b1;
    repeat (8) tick();
    chk("ch0_bounce_released", 32'(level[0]), 32'h0);
    chk("ch0_bounce_ev_count", 32'(ev_cnt[0] - b_ev), 32'd1);
    chk("ch0_bounce_rise_count", 32'(rise_cnt[0] - b_rise), 32'd1);

    // auto-repeat on down; release accepted on the edge a repeat would fire
    b_ev = ev_cnt[BTN_DOWN];
    raw_n[BTN_DOWN] = 1'b0;
    repeat (6) tick();
    for (int k = 0; k <= 34; k++) begin
      chk($sformatf("ch1_rep_k%0d", k), 32'({level[1], ev[1]}), 32'({k < 31, exp_ev(k, 31)}));
      if (k == 25) raw_n[BTN_DOWN] = 1'b1;
      tick();
    end
`ifdef BTN_AUTOREPEAT_EN
    chk("ch1_rep_ev_count", 32'(ev_cnt[1] - b_ev), 32'd8);
`else
    chk("ch1_rep_ev_count", 32'(ev_cnt[1] - b_ev), 32'd1);
`endif

    // masked set_alarm held 40 cycles
    b_ev = ev_cnt[BTN_SET_ALARM];
    raw_n[BTN_SET_ALARM] = 1'b0;
    repeat (6) tick();
    chk("ch3_event_accept", 32'(ev[3]), 32'h1);
    repeat (40) tick();
    chk("ch3_level_held", 32'(level[3]), 32'h1);
    raw_n[BTN_SET_ALARM] = 1'b1;
    repeat (8) tick();
    chk("ch3_released", 32'(level[3]), 32'h0);
    chk("ch3_ev_count", 32'(ev_cnt[3] - b_ev), 32'd1);

    // up and down together; up released mid-repeat
    raw_n[1:0] = 2'b00;
    repeat (6) tick();
    for (int k = 0; k <= 33; k++) begin
      chk($sformatf("sim_k%0d", k), 32'({level[1:0], ev[1:0]}),
          32'({k < 30, k < 18, exp_ev(k, 30), exp_ev(k, 18)}));
      if (k == 12) raw_n[BTN_UP] = 1'b1;
      if (k == 24) raw_n[BTN_DOWN] = 1'b1;
      tick();
    end
    chk("final_idle", 32'({level, ev}), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioner for the alarm clock's four push-buttons: up, down, set-clock and set-alarm. Each raw, bouncing, asynchronous button is synchronised and debounced into a clean level. The block emits one-cycle event pulses on press, plus optional auto-repeat pulses while up/down are held. It sits directly upstream of the system's `btn_*_export` PIO inputs and produces the signals the CPU polls.

## Interface
Parameters:
- `N_BTN`, 4 — number of channels. Bit order: 0 = up, 1 = down, 2 = set_clock, 3 = set_alarm.
- `DEBOUNCE_CYCLES`, 1_000_000 — consecutive stable cycles required to accept a change (20 ms at 50 MHz); must be ≥ 2.
- `REPEAT_DELAY`, 25_000_000 — held cycles after the press event before the first repeat event.
- `REPEAT_PERIOD`, 10_000_000 — cycles between subsequent repeat events.
- `REPEAT_MASK`, 4'b0011 — channels allowed to auto-repeat.

Ports:
- `clk_clk` in 1 — system clock.
- `reset_reset_n` in 1 — reset. Asynchronous, active-low.
- `btn_raw_n` in N_BTN — raw board keys, active-low, asynchronous.
- `btn_level` out N_BTN — debounced state, 1 = pressed; feeds the PIO `btn_*_export`.
- `btn_event` out N_BTN — one-cycle pulse per press and per repeat.

## Operation
- **Channel independence:** each channel is fully independent; simultaneous activity on several channels never interacts.
- **Synchroniser:** each input passes through a 2-FF synchroniser with an inversion so that 1 = pressed. Synchroniser flops reset to 0 (released).
- **Debounce counter:**
  - Counts consecutive cycles in which the synchronised value differs from `btn_level`.
  - Clears to 0 on any cycle where they match (a bounce restarts the count).
  - When the count reaches DEBOUNCE_CYCLES−1 while still differing, `btn_level` toggles on the next edge and the count clears.
- **Per-channel FSM, states IDLE, HELD, REPEAT:**
  - IDLE → HELD when `btn_level` rises. `btn_event` pulses in the first cycle `btn_level` reads 1. The repeat counter loads 0.
  - HELD: the repeat counter increments every cycle. When it reaches REPEAT_DELAY−1, `btn_event` pulses, the FSM goes to REPEAT and the counter clears. This applies only if the channel's REPEAT_MASK bit is set; otherwise the FSM stays in HELD with the counter frozen.
  - REPEAT: the counter increments. At REPEAT_PERIOD−1, `btn_event` pulses and the counter clears.
  - Any state → IDLE when `btn_level` falls. No event is generated on release.
- **Counter widths:** the repeat counter is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD))` bits; the debounce counter is `$clog2(DEBOUNCE_CYCLES)` bits. Neither counter ever wraps: they clear exactly at terminal count.
- **Release during HELD/REPEAT:** if release is accepted in the same cycle a repeat would fire, release wins and no pulse is emitted.
- **Reset mid-operation:** all state returns to IDLE/released. A button still held after reset deasserts is debounced from scratch and yields a normal press event.

## Timing
- **Reset values:** `btn_level` = 0 and `btn_event` = 0 while reset is asserted; all outputs are registered.
- **Press latency:** the raw input falls and stays low. `btn_level` rises on the (2 + DEBOUNCE_CYCLES)th rising edge after the first edge that samples it low. `btn_event` is high during that same cycle only.
- **Release latency:** identical on release.
- **Event width:** `btn_event` is always exactly one cycle wide. The minimum spacing between events on a channel is REPEAT_PERIOD cycles.
- **Metastability:** the asynchronous input is only ever observed after the second synchroniser flop.

## Configuration
- **`BTN_AUTOREPEAT_EN` defined:** HELD/REPEAT auto-repeat is active as described above.
- **`BTN_AUTOREPEAT_EN` undefined:**
  - The repeat counter and the REPEAT state are not compiled; REPEAT_MASK is ignored.
  - The FSM reduces to IDLE/HELD, and `btn_event` fires only once per accepted press.

## Structure
- **Package `btn_pkg`:** the channel FSM state enum (IDLE, HELD, REPEAT), channel index constants (BTN_UP=0, BTN_DOWN=1, BTN_SET_CLOCK=2, BTN_SET_ALARM=3), and a default REPEAT_MASK constant.
- **Sub-module `btn_channel`:** one synchroniser + debounce + FSM per channel, with a `repeat_en` input. The top instantiates it N_BTN times in a generate loop, tying `repeat_en` to `REPEAT_MASK[i]`.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- **Reset:** assert reset with all raw inputs 0 (pressed) → `btn_level`=0 and `btn_event`=0 during reset. After deassert, the level rises 6 cycles later with a single event on each channel.
- **Clean press/release on ch2:** raw low at edge 0 → level=1 and event pulse at edge 6. Raw high at edge 20 → level=0 at edge 26, with no event on release.
- **Bounce on ch0:** raw toggles low/high/low with 2-cycle gaps, then stays low → exactly one event, 6 cycles after the final transition. Level never glitches.
- **Auto-repeat on ch1, held 30 cycles after acceptance:** events at acceptance, +10, +13, +16 … (first event plus 7 repeats), and no event after release. With the macro undefined, exactly one event.
- **Masked channel ch3, held 40 cycles:** exactly one event.
- **Simultaneous presses:** ch0 and ch1 pressed on the same edge → identical, cycle-aligned event patterns. Releasing ch0 mid-repeat does not perturb ch1's repeat phase.
